// File: rtl/node_stream_sweeper.sv
// Streams every clause row of one variable assignment through a run-time loadable literal
// memory, ORs in the assignment mask and flags the first row with a fully falsified clause.
module node_stream_sweeper #(
  parameter int unsigned NUM_CLAUSES           = 64,
  parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
  parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
  parameter int unsigned VAR_ID_BITS           = 8,
  parameter int unsigned EARLY_ABORT           = 1,
  localparam int unsigned NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned PTR_BITS = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned W        = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned SLOT_W   = VAR_ID_BITS + 1,
  localparam int unsigned MEM_W    = SLOT_W * W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [VAR_ID_BITS-1:0] assign_var_id,
  input  logic                   assign_var_val,
  input  logic                   lit_wr_en,
  input  logic [PTR_BITS-1:0]    lit_wr_row,
  input  logic [MEM_W-1:0]       lit_wr_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_clauses,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_clauses,
  output logic [PTR_BITS-1:0]    out_row,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   is_node_unsat,
  output logic [PTR_BITS-1:0]    unsat_row
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [PTR_BITS-1:0] LastRow  = PTR_BITS'(NUM_ROWS - 1);
  localparam logic [PTR_BITS:0]   RowCount = (PTR_BITS + 1)'(NUM_ROWS);

  logic [1:0]             state_q, state_d;
  logic [PTR_BITS-1:0]    row_ptr_q, row_ptr_d;
  logic [VAR_ID_BITS-1:0] var_id_q, var_id_d;
  logic                   var_val_q, var_val_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           out_clauses_q, out_clauses_d;
  logic [PTR_BITS-1:0]    out_row_q, out_row_d;
  logic                   out_last_q, out_last_d;
  logic                   unsat_q, unsat_d;
  logic [PTR_BITS-1:0]    unsat_row_q, unsat_row_d;

  logic [MEM_W-1:0] lit_mem [NUM_ROWS];
  logic [MEM_W-1:0] lit_row;
  logic [W-1:0]     mask;
  logic [W-1:0]     merged;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] clause_unsat;
  logic             beat_unsat;
  logic             accept;
  logic             last_beat;
  logic             mem_we;

  // Literal memory has no reset: contents survive a mid-sweep reset.
  assign mem_we = (state_q == StIdle) && lit_wr_en && ({1'b0, lit_wr_row} < RowCount);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      lit_mem[lit_wr_row] <= lit_wr_data;
    end
  end

  assign lit_row = lit_mem[row_ptr_q];

  for (genvar i = 0; i < W; i++) begin : g_mask
    logic [VAR_ID_BITS-1:0] slot_id;
    logic                   slot_neg;
    assign {slot_neg, slot_id} = lit_row[i*SLOT_W +: SLOT_W];
    // Positive literal falsified by False (val=1), negated literal by True (val=0).
    assign mask[i] = (slot_id == var_id_q) && (slot_id != '0) && (slot_neg != var_val_q);
  end

  assign merged = in_clauses | mask;

  for (genvar c = 0; c < NUM_CLAUSES_PER_CYCLE; c++) begin : g_clause
    assign clause_unsat[c] = &merged[c*NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE];
  end

  assign beat_unsat = |clause_unsat;
  assign in_ready   = (state_q == StSweep) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_beat  = (row_ptr_q == LastRow) || ((EARLY_ABORT != 0) && beat_unsat);

  always_comb begin
    state_d       = state_q;
    row_ptr_d     = row_ptr_q;
    var_id_d      = var_id_q;
    var_val_d     = var_val_q;
    out_valid_d   = out_valid_q;
    out_clauses_d = out_clauses_q;
    out_row_d     = out_row_q;
    out_last_d    = out_last_q;
    unsat_d       = unsat_q;
    unsat_row_d   = unsat_row_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSweep;
          var_id_d    = assign_var_id;
          var_val_d   = assign_var_val;
          row_ptr_d   = '0;
          unsat_d     = 1'b0;
          unsat_row_d = '0;
        end
      end
      StSweep: begin
        if (accept) begin
          out_valid_d   = 1'b1;
          out_clauses_d = merged;
          out_row_d     = row_ptr_q;
          out_last_d    = last_beat;
          row_ptr_d     = (row_ptr_q == LastRow) ? '0 : row_ptr_q + 1'b1;
          if (beat_unsat && !unsat_q) begin
            unsat_d     = 1'b1;
            unsat_row_d = row_ptr_q;
          end
          if (last_beat) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      row_ptr_q     <= '0;
      var_id_q      <= '0;
      var_val_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_clauses_q <= '0;
      out_row_q     <= '0;
      out_last_q    <= 1'b0;
      unsat_q       <= 1'b0;
      unsat_row_q   <= '0;
    end else begin
      state_q       <= state_d;
      row_ptr_q     <= row_ptr_d;
      var_id_q      <= var_id_d;
      var_val_q     <= var_val_d;
      out_valid_q   <= out_valid_d;
      out_clauses_q <= out_clauses_d;
      out_row_q     <= out_row_d;
      out_last_q    <= out_last_d;
      unsat_q       <= unsat_d;
      unsat_row_q   <= unsat_row_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_clauses   = out_clauses_q;
  assign out_row       = out_row_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign is_node_unsat = unsat_q;
  assign unsat_row     = unsat_row_q;

endmodule

// File: tb/tb_node_stream_sweeper.sv
// Bench for node_stream_sweeper: fixed vector table, hand-built corner sequences and
// randomized sweeps checked against a clause-level reference model.
module tb_node_stream_sweeper;

  localparam int unsigned NV = 3;
  localparam int unsigned VB = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned PB = 1;
  localparam int unsigned W  = 12;
  localparam int unsigned SW = VB + 1;
  localparam int unsigned MW = SW * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [VB-1:0] assign_var_id;
  logic          assign_var_val;
  logic          lit_wr_en;
  logic [PB-1:0] lit_wr_row;
  logic [MW-1:0] lit_wr_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_clauses;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_clauses;
  logic [PB-1:0] out_row;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          is_node_unsat;
  logic [PB-1:0] unsat_row;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  node_stream_sweeper #(
    .NUM_CLAUSES          (8),
    .NUM_CLAUSES_PER_CYCLE(4),
    .NUM_VARS_PER_CLAUSE  (3),
    .VAR_ID_BITS          (4),
    .EARLY_ABORT          (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .assign_var_id (assign_var_id),
    .assign_var_val(assign_var_val),
    .lit_wr_en     (lit_wr_en),
    .lit_wr_row    (lit_wr_row),
    .lit_wr_data   (lit_wr_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_clauses    (in_clauses),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_clauses   (out_clauses),
    .out_row       (out_row),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .is_node_unsat (is_node_unsat),
    .unsat_row     (unsat_row)
  );

  typedef struct {
    logic [W-1:0]  cl;
    logic [PB-1:0] row;
    logic          last;
  } beat_t;

  typedef struct {
    logic [VB-1:0] id;
    logic          val;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    int            mode;
    int            nb;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
    logic          eu;
    logic [PB-1:0] er;
  } vec_t;

  // Reference literal store: one (id, negated) pair per clause slot.
  logic [VB-1:0] m_id  [NR][W];
  bit            m_pol [NR][W];
  beat_t         exp_q [$];

  int init_id [NR][W] = '{'{1, 2, 3, 2, 0, 4, 6, 7, 3, 2, 1, 4},
                          '{2, 3, 3, 1, 4, 2, 0, 6, 7, 1, 2, 3}};
  bit init_pol[NR][W] = '{'{0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0},
                          '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [MW-1:0] pack_row(input int r);
    logic [MW-1:0] d;
    d = '0;
    for (int s = 0; s < W; s++) d[s*SW +: SW] = {m_pol[r][s], m_id[r][s]};
    return d;
  endfunction

  task automatic write_row(input int r);
    @(negedge clk);
    lit_wr_en   = 1'b1;
    lit_wr_row  = PB'(r);
    lit_wr_data = pack_row(r);
    @(negedge clk);
    lit_wr_en = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_clauses"}, out_clauses, 0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_unsat"}, is_node_unsat, 0);
    chk({tag, "_unsat_row"}, unsat_row, 0);
  endtask

  // Clause-level model: a slot is falsified by the input bit or by the assignment;
  // a row is UNSAT when some clause has every slot falsified; sweep stops there.
  task automatic build_expect(input logic [VB-1:0] id, input logic val,
                              input logic [W-1:0] in0, input logic [W-1:0] in1,
                              output logic eu, output logic [PB-1:0] er);
    logic [W-1:0] ins [NR];
    logic [W-1:0] w;
    bit           u;
    bit           all;
    beat_t        b;
    exp_q.delete();
    eu = 1'b0;
    er = '0;
    ins[0] = in0;
    ins[1] = in1;
    for (int r = 0; r < NR; r++) begin
      w = ins[r];
      for (int s = 0; s < W; s++) begin
        if (m_id[r][s] != 0 && m_id[r][s] == id && m_pol[r][s] != val) w[s] = 1'b1;
      end
      u = 1'b0;
      for (int c = 0; c < W / NV; c++) begin
        all = 1'b1;
        for (int k = 0; k < NV; k++) if (!w[c*NV+k]) all = 1'b0;
        if (all) u = 1'b1;
      end
      b.cl   = w;
      b.row  = PB'(r);
      b.last = (r == NR - 1) || u;
      exp_q.push_back(b);
      if (u) begin
        eu = 1'b1;
        er = PB'(r);
        break;
      end
    end
  endtask

  // mode 0: always ready; 1: random valid/ready; 2: out_ready low for cycles 2..4.
  task automatic run_sweep(input logic [VB-1:0] id, input logic val,
                           input logic [W-1:0] in0, input logic [W-1:0] in1,
                           input int mode, input bit disturb, input bit wr,
                           input logic [PB-1:0] wr_row, input logic eu, input logic [PB-1:0] er);
    logic [W-1:0]  ins [NR];
    logic [W-1:0]  pc;
    logic [PB-1:0] pr;
    logic          pl;
    bit            prev_stall;
    bit            fin;
    int            fed;
    int            got;
    int            n_exp;
    ins[0] = in0;
    ins[1] = in1;
    n_exp = exp_q.size();
    @(negedge clk);
    start          = 1'b1;
    assign_var_id  = id;
    assign_var_val = val;
    out_ready      = 1'b1;
    in_valid       = 1'b0;
    if (wr) begin
      lit_wr_en   = 1'b1;
      lit_wr_row  = wr_row;
      lit_wr_data = pack_row(int'(wr_row));
    end
    @(negedge clk);
    start          = 1'b0;
    lit_wr_en      = 1'b0;
    assign_var_id  = VB'($urandom);
    assign_var_val = 1'($urandom);
    fed = 0;
    got = 0;
    fin = 1'b0;
    prev_stall = 1'b0;
    pc = '0;
    pr = '0;
    pl = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      case (mode)
        1:       out_ready = ($urandom_range(0, 2) != 0);
        2:       out_ready = !(cyc >= 2 && cyc < 5);
        default: out_ready = 1'b1;
      endcase
      in_valid   = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_clauses = (fed < NR) ? ins[fed] : W'($urandom);
      if (disturb && cyc == 1) begin
        start          = 1'b1;
        assign_var_id  = 4'd15;
        lit_wr_en      = 1'b1;
        lit_wr_row     = '0;
        lit_wr_data    = '1;
      end else begin
        start     = 1'b0;
        lit_wr_en = 1'b0;
      end
      #1;
      if (cyc == 0) chk("busy_in_sweep", busy, 1);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_clauses", out_clauses, pc);
        chk("hold_row", out_row, pr);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      prev_stall = out_valid && !out_ready;
      pc = out_clauses;
      pr = out_row;
      pl = out_last;
      if (out_valid && out_ready) begin
        if (got < n_exp) begin
          chk("beat_clauses", out_clauses, exp_q[got].cl);
          chk("beat_row", out_row, exp_q[got].row);
          chk("beat_last", out_last, exp_q[got].last);
        end
        got++;
      end
      if (in_valid && in_ready) fed++;
      if (done) fin = 1'b1;
      @(negedge clk);
    end
    start     = 1'b0;
    lit_wr_en = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("sweep_done_seen", fin, 1);
    chk("beat_count", got, n_exp);
    chk("rows_consumed", fed, n_exp);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("unsat_flag", is_node_unsat, eu);
    if (eu) chk("unsat_row", unsat_row, er);
  endtask

  task automatic run_vec(input vec_t v, input bit disturb);
    beat_t b;
    exp_q.delete();
    b.cl = v.e0; b.row = 1'b0; b.last = (v.nb == 1);
    exp_q.push_back(b);
    if (v.nb == 2) begin
      b.cl = v.e1; b.row = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
    end
    run_sweep(v.id, v.val, v.in0, v.in1, v.mode, disturb, 1'b0, '0, v.eu, v.er);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t          vt [6];
    logic [VB-1:0] id;
    logic          val;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    logic          eu;
    logic [PB-1:0] er;
    int            r;

    vt[0] = '{4'd2, 1'b0, 12'h005, 12'h000, 0, 1, 12'h007, 12'h000, 1'b1, 1'b0};
    vt[1] = '{4'd5, 1'b0, 12'h001, 12'h000, 0, 2, 12'h001, 12'h000, 1'b0, 1'b0};
    vt[2] = '{4'd2, 1'b1, 12'h000, 12'h018, 1, 2, 12'h208, 12'h038, 1'b1, 1'b1};
    vt[3] = '{4'd3, 1'b0, 12'h040, 12'h003, 2, 2, 12'h140, 12'h007, 1'b1, 1'b1};
    vt[4] = '{4'd1, 1'b1, 12'he00, 12'h000, 1, 1, 12'he01, 12'h000, 1'b1, 1'b0};
    vt[5] = '{4'd0, 1'b1, 12'h000, 12'h180, 0, 2, 12'h000, 12'h180, 1'b0, 1'b0};

    for (int rr = 0; rr < NR; rr++) begin
      for (int s = 0; s < W; s++) begin
        m_id[rr][s]  = VB'(init_id[rr][s]);
        m_pol[rr][s] = init_pol[rr][s];
      end
    end

    // Reset with noisy inputs, then release quietly.
    reset          = 1'b1;
    start          = 1'($urandom);
    assign_var_id  = VB'($urandom);
    assign_var_val = 1'($urandom);
    lit_wr_en      = 1'($urandom);
    lit_wr_row     = PB'($urandom);
    lit_wr_data    = {MW{1'b1}};
    in_valid       = 1'($urandom);
    in_clauses     = W'($urandom);
    out_ready      = 1'($urandom);
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    reset     = 1'b0;
    start     = 1'b0;
    lit_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("post_reset");

    write_row(0);
    write_row(1);

    for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b0);

    // start / write during SWEEP must not restart or touch memory; read back afterwards.
    run_vec(vt[1], 1'b1);
    run_vec(vt[0], 1'b0);

    // Reset right after the row-0 handshake.
    @(negedge clk);
    start          = 1'b1;
    assign_var_id  = 4'd5;
    assign_var_val = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    in_valid   = 1'b1;
    in_clauses = 12'h001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    run_vec(vt[0], 1'b0);

    // Randomized sweeps, with occasional memory rewrites (some in the start cycle).
    for (int n = 0; n < 40; n++) begin
      bit wr_now;
      wr_now = 1'b0;
      r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 2) == 0) begin
        for (int s = 0; s < W; s++) begin
          m_id[r][s]  = VB'($urandom_range(0, 7));
          m_pol[r][s] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 1) == 0) wr_now = 1'b1;
        else write_row(r);
      end
      id  = VB'($urandom_range(0, 7));
      val = 1'($urandom_range(0, 1));
      in0 = ($urandom_range(0, 1) == 0) ? W'($urandom | $urandom) : W'($urandom & $urandom);
      in1 = ($urandom_range(0, 1) == 0) ? W'($urandom | $urandom) : W'($urandom & $urandom);
      build_expect(id, val, in0, in1, eu, er);
      run_sweep(id, val, in0, in1, 1, 1'b0, wr_now, PB'(r), eu, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
